// File: rtl/lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_ctrl
//   Write-only 4-bit bus controller for an HD44780-class character LCD.
//   After reset it waits out the LCD power-up time, runs the 4-bit init
//   sequence (nibbles 3,3,3,2 then bytes 28,0C,01,06), raises init_done and
//   then accepts command/data bytes over a valid/ready handshake. Every byte
//   is sent as two nibbles (high first) with setup / E-pulse / hold timing,
//   followed by the LCD execution delay.
//
// Ports
//   sys0_clk   : clock
//   sys0_rstn  : asynchronous active-low reset
//   cmd_valid  : byte request present
//   cmd_ready  : controller idle and initialised, byte will be taken
//   cmd_rs     : 0 = instruction, 1 = data
//   cmd_data   : byte to send
//   init_done  : init sequence finished (sticky until reset)
//   lcd_db     : LCD data nibble (registered)
//   lcd_e      : LCD enable strobe (registered)
//   lcd_rs     : LCD register select (registered)
//   lcd_rw     : LCD read/write, tied to write (0)
// -----------------------------------------------------------------------------
module lcd_hd44780_ctrl #(
   parameter int T_PWRUP     = 3000000,
   parameter int T_INIT1     = 820000,
   parameter int T_SETUP     = 8,
   parameter int T_EPW       = 50,
   parameter int T_HOLD      = 4,
   parameter int T_EXEC      = 8000,
   parameter int T_EXEC_LONG = 328000,
   parameter int CW          = 22
) (
   input  logic       sys0_clk,
   input  logic       sys0_rstn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       init_done,
   output logic [3:0] lcd_db,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw
);

   typedef enum logic [3:0] {
      ST_PWRUP,
      ST_N_SETUP,
      ST_N_PULSE,
      ST_N_HOLD,
      ST_WAIT,
      ST_IDLE,
      ST_SETUP_H,
      ST_PULSE_H,
      ST_HOLD_H,
      ST_SETUP_L,
      ST_PULSE_L,
      ST_HOLD_L
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      step_q, step_d;    // init step: 0-3 nibbles, 4-7 bytes
   logic [7:0]      byte_q, byte_d;    // byte (or low-nibble) being sent
   logic            rs_q, rs_d;        // rs of the byte being sent
   logic            done_d;
   logic            cnt_zero;
   logic            nib_mode;
   logic [3:0]      db_d;
   logic            e_d;
   logic            lrs_d;

   // Init nibble table (steps 0..3).
   function automatic logic [3:0] init_nib(input logic [2:0] idx);
      logic [3:0] n;
      n = 4'h3;
      if (idx == 3'd3) n = 4'h2;
      return n;
   endfunction

   // Init byte table (steps 4..7).
   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd4:    b = 8'h28;   // 4-bit bus, 2 lines, 5x8 font
         3'd5:    b = 8'h0C;   // display on, cursor off
         3'd6:    b = 8'h01;   // clear
         default: b = 8'h06;   // entry mode: increment, no shift
      endcase
      return b;
   endfunction

   // Counter reload for a state: T-1 so the state lasts exactly T cycles.
   // The WAIT length depends on what was just sent: the first init nibble
   // needs the long 4.1 ms gap, clear/home (instr 01..03) need the long
   // execution time, everything else the normal one.
   function automatic logic [CW-1:0] load_val(input state_t s,
                                              input logic nib,
                                              input logic [2:0] step,
                                              input logic rs,
                                              input logic [7:0] b);
      int t;
      t = 1;
      case (s)
         ST_PWRUP:                           t = T_PWRUP;
         ST_N_SETUP, ST_SETUP_H, ST_SETUP_L: t = T_SETUP;
         ST_N_PULSE, ST_PULSE_H, ST_PULSE_L: t = T_EPW;
         ST_N_HOLD,  ST_HOLD_H,  ST_HOLD_L:  t = T_HOLD;
         ST_WAIT: begin
            if (nib)
               t = (step == 3'd0) ? T_INIT1 : T_EXEC;
            else if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
               t = T_EXEC_LONG;
            else
               t = T_EXEC;
         end
         default:                            t = 1;
      endcase
      return CW'(t - 1);
   endfunction

   assign cnt_zero  = (cnt_q == '0);
   // Nibble-only writes happen only during the first four init steps.
   assign nib_mode  = !init_done && !step_q[2];
   assign cmd_ready = (state_q == ST_IDLE) && init_done;
   assign lcd_rw    = 1'b0;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
      if (!sys0_rstn) begin
         state_q   <= ST_PWRUP;
         cnt_q     <= CW'(T_PWRUP - 1);
         step_q    <= '0;
         byte_q    <= '0;
         rs_q      <= 1'b0;
         init_done <= 1'b0;
         lcd_db    <= '0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         byte_q    <= byte_d;
         rs_q      <= rs_d;
         init_done <= done_d;
         lcd_db    <= db_d;
         lcd_e     <= e_d;
         lcd_rs    <= lrs_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 1'b1;
      step_d  = step_q;
      byte_d  = byte_q;
      rs_d    = rs_q;
      done_d  = init_done;

      case (state_q)
         ST_PWRUP: if (cnt_zero) begin
            state_d = ST_N_SETUP;
            byte_d  = {4'h0, init_nib(3'd0)};
            rs_d    = 1'b0;
         end
         ST_N_SETUP: if (cnt_zero) state_d = ST_N_PULSE;
         ST_N_PULSE: if (cnt_zero) state_d = ST_N_HOLD;
         ST_N_HOLD:  if (cnt_zero) state_d = ST_WAIT;
         ST_SETUP_H: if (cnt_zero) state_d = ST_PULSE_H;
         ST_PULSE_H: if (cnt_zero) state_d = ST_HOLD_H;
         ST_HOLD_H:  if (cnt_zero) state_d = ST_SETUP_L;
         ST_SETUP_L: if (cnt_zero) state_d = ST_PULSE_L;
         ST_PULSE_L: if (cnt_zero) state_d = ST_HOLD_L;
         ST_HOLD_L:  if (cnt_zero) state_d = ST_WAIT;
         ST_WAIT: if (cnt_zero) begin
            if (init_done) begin
               state_d = ST_IDLE;
            end else if (step_q == 3'd7) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               step_d = step_q + 3'd1;
               rs_d   = 1'b0;
               if (step_q < 3'd3) begin
                  state_d = ST_N_SETUP;
                  byte_d  = {4'h0, init_nib(step_q + 3'd1)};
               end else begin
                  state_d = ST_SETUP_H;
                  byte_d  = init_byte(step_q + 3'd1);
               end
            end
         end
         ST_IDLE: begin
            cnt_d = cnt_q;
            if (cmd_valid && cmd_ready) begin
               state_d = ST_SETUP_H;
               byte_d  = cmd_data;
               rs_d    = cmd_rs;
            end
         end
         default: state_d = ST_PWRUP;
      endcase

      // Every state change reloads the counter for the state being entered.
      if (state_d != state_q)
         cnt_d = load_val(state_d, nib_mode, step_d, rs_d, byte_d);
   end

   // -------------------------------------------------------------------------
   // Output logic: computed from the next state so the pins are registered
   // yet line up cycle-for-cycle with the state register.
   // -------------------------------------------------------------------------
   always_comb begin
      e_d   = 1'b0;
      db_d  = lcd_db;    // db/rs hold their last value in IDLE and WAIT
      lrs_d = lcd_rs;
      case (state_d)
         ST_N_SETUP, ST_N_HOLD: begin
            db_d  = byte_d[3:0];
            lrs_d = 1'b0;
         end
         ST_N_PULSE: begin
            db_d  = byte_d[3:0];
            lrs_d = 1'b0;
            e_d   = 1'b1;
         end
         ST_SETUP_H, ST_HOLD_H: begin
            db_d  = byte_d[7:4];
            lrs_d = rs_d;
         end
         ST_PULSE_H: begin
            db_d  = byte_d[7:4];
            lrs_d = rs_d;
            e_d   = 1'b1;
         end
         ST_SETUP_L, ST_HOLD_L: begin
            db_d  = byte_d[3:0];
            lrs_d = rs_d;
         end
         ST_PULSE_L: begin
            db_d  = byte_d[3:0];
            lrs_d = rs_d;
            e_d   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
module tb_lcd_hd44780_ctrl;

   localparam int T_PWRUP     = 20;
   localparam int T_INIT1     = 10;
   localparam int T_SETUP     = 2;
   localparam int T_EPW       = 3;
   localparam int T_HOLD      = 1;
   localparam int T_EXEC      = 5;
   localparam int T_EXEC_LONG = 12;
   localparam int INIT_CYC    = 144;

   logic       sys0_clk = 1'b0;
   logic       sys0_rstn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rs = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       init_done;
   logic [3:0] lcd_db;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] db;
      logic       rs;
      int         width;
   } pulse_t;

   typedef struct {
      logic [3:0] db;
      logic       rs;
   } exp_t;

   pulse_t obs_q[$];
   exp_t   exp_q[$];
   bit     rw_bad = 1'b0;

   lcd_hd44780_ctrl #(
      .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_SETUP(T_SETUP), .T_EPW(T_EPW),
      .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CW(22)
   ) dut (
      .sys0_clk(sys0_clk), .sys0_rstn(sys0_rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
      .cmd_data(cmd_data), .init_done(init_done),
      .lcd_db(lcd_db), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
   );

   always #5 sys0_clk = ~sys0_clk;

   // Pulse monitor: records db/rs at the start of each E pulse and its width.
   // Pulses cut short by reset are dropped.
   initial begin
      logic       in_pulse;
      int         wcnt;
      logic [3:0] p_db;
      logic       p_rs;
      in_pulse = 1'b0;
      wcnt = 0;
      p_db = '0;
      p_rs = 1'b0;
      forever begin
         @(negedge sys0_clk);
         if (lcd_rw !== 1'b0) rw_bad = 1'b1;
         if (!sys0_rstn) begin
            in_pulse = 1'b0;
         end else if (lcd_e === 1'b1) begin
            if (!in_pulse) begin
               in_pulse = 1'b1;
               wcnt = 0;
               p_db = lcd_db;
               p_rs = lcd_rs;
            end
            wcnt++;
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            obs_q.push_back('{db: p_db, rs: p_rs, width: wcnt});
         end
      end
   end

   task automatic push_byte(input logic rs, input logic [7:0] d);
      exp_q.push_back('{db: d[7:4], rs: rs});
      exp_q.push_back('{db: d[3:0], rs: rs});
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys0_clk);
      checks++;
      if ({lcd_e, lcd_db, lcd_rs, lcd_rw, cmd_ready, init_done} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got e=%b db=%h rs=%b rw=%b rdy=%b done=%b expected all 0",
                  lcd_e, lcd_db, lcd_rs, lcd_rw, cmd_ready, init_done);
      end
   endtask

   // Releases reset and checks the full init sequence; optionally wiggles the
   // command inputs throughout, which must have no effect.
   task automatic test_init(input string name, input bit toggle);
      logic [3:0] nibs [12];
      int n;
      nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 12; i++) exp_q.push_back('{db: nibs[i], rs: 1'b0});
      @(negedge sys0_clk);
      sys0_rstn = 1'b1;
      n = 0;
      while (n < 400) begin
         if (toggle) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_rs    = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
         end
         @(negedge sys0_clk);
         n++;
         if (init_done === 1'b1) break;
      end
      cmd_valid = 1'b0;
      checks++;
      if (n != INIT_CYC) begin
         errors++;
         $display("FAIL %s init_done_cycle got %0d expected %0d", name, n, INIT_CYC);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after_init got %b expected 1", name, cmd_ready);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s init_pulse_count got %0d expected %0d", name, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         pulse_t o;
         exp_t   e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.db !== e.db || o.rs !== e.rs || o.width != T_EPW) begin
            errors++;
            $display("FAIL %s init_pulse got db=%h rs=%b w=%0d expected db=%h rs=%b w=%0d",
                     name, o.db, o.rs, o.width, e.db, e.rs, T_EPW);
         end
      end
      obs_q.delete();
      exp_q.delete();
      checks++;
      if (rw_bad) begin
         errors++;
         $display("FAIL %s lcd_rw got 1 expected 0", name);
      end
   endtask

   // Single bytes with their expected busy (cmd_ready low) time.
   task automatic test_bytes();
      logic       t_rs  [7];
      logic [7:0] t_dat [7];
      int         t_low [7];
      t_rs  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
      t_dat = '{8'h41, 8'h01, 8'h04, 8'h01, 8'h02, 8'h03, 8'h00};
      t_low = '{17,    24,    17,    17,    24,    24,    17};
      for (int i = 0; i < 7; i++) begin
         int n;
         obs_q.delete();
         exp_q.delete();
         n = 0;
         while (cmd_ready !== 1'b1 && n < 100) begin @(negedge sys0_clk); n++; end
         cmd_valid = 1'b1;
         cmd_rs    = t_rs[i];
         cmd_data  = t_dat[i];
         push_byte(t_rs[i], t_dat[i]);
         @(negedge sys0_clk);
         cmd_valid = 1'b0;
         n = 0;
         while (cmd_ready !== 1'b1 && n < 100) begin n++; @(negedge sys0_clk); end
         checks++;
         if (n != t_low[i]) begin
            errors++;
            $display("FAIL byte_busy rs=%b d=%h got %0d cycles expected %0d",
                     t_rs[i], t_dat[i], n, t_low[i]);
         end
         checks++;
         if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL byte_pulse_count d=%h got %0d expected 2", t_dat[i], obs_q.size());
         end
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            pulse_t o;
            exp_t   e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.db !== e.db || o.rs !== e.rs || o.width != T_EPW) begin
               errors++;
               $display("FAIL byte_pulse d=%h got db=%h rs=%b w=%0d expected db=%h rs=%b w=%0d",
                        t_dat[i], o.db, o.rs, o.width, e.db, e.rs, T_EPW);
            end
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int n1, h, n2;
      obs_q.delete();
      exp_q.delete();
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h48;
      push_byte(1'b1, 8'h48);
      @(negedge sys0_clk);
      cmd_data = 8'h49;
      push_byte(1'b1, 8'h49);
      n1 = 0;
      while (cmd_ready !== 1'b1 && n1 < 100) begin n1++; @(negedge sys0_clk); end
      h = 0;
      while (cmd_ready === 1'b1 && h < 100) begin h++; @(negedge sys0_clk); end
      cmd_valid = 1'b0;
      n2 = 0;
      while (cmd_ready !== 1'b1 && n2 < 100) begin n2++; @(negedge sys0_clk); end
      checks++;
      if (n1 != 17 || h != 1 || n2 != 17) begin
         errors++;
         $display("FAIL b2b_ready low1=%0d high=%0d low2=%0d expected 17/1/17", n1, h, n2);
      end
      checks++;
      if (obs_q.size() != 4) begin
         errors++;
         $display("FAIL b2b_pulse_count got %0d expected 4", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         pulse_t o;
         exp_t   e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.db !== e.db || o.rs !== e.rs || o.width != T_EPW) begin
            errors++;
            $display("FAIL b2b_pulse got db=%h rs=%b w=%0d expected db=%h rs=%b w=%0d",
                     o.db, o.rs, o.width, e.db, e.rs, T_EPW);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // Command inputs wiggling while a byte is in flight must be ignored.
   task automatic test_ignore_busy();
      int n;
      obs_q.delete();
      exp_q.delete();
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h41;
      push_byte(1'b1, 8'h41);
      @(negedge sys0_clk);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         n++;
         if (n < 14) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_rs    = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge sys0_clk);
      end
      cmd_valid = 1'b0;
      repeat (10) @(negedge sys0_clk);
      checks++;
      if (n != 17) begin
         errors++;
         $display("FAIL ignore_busy_ready got %0d cycles expected 17", n);
      end
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL ignore_busy_pulses got %0d expected 2", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         pulse_t o;
         exp_t   e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.db !== e.db || o.rs !== e.rs) begin
            errors++;
            $display("FAIL ignore_busy_pulse got db=%h rs=%b expected db=%h rs=%b",
                     o.db, o.rs, e.db, e.rs);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // Reset asserted while E is high on the first nibble of a data byte.
   task automatic test_reset_mid();
      int n;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h55;
      @(negedge sys0_clk);
      cmd_valid = 1'b0;
      n = 0;
      while (lcd_e !== 1'b1 && n < 50) begin @(negedge sys0_clk); n++; end
      checks++;
      if (lcd_e !== 1'b1 || lcd_db !== 4'h5 || lcd_rs !== 1'b1) begin
         errors++;
         $display("FAIL mid_pulse_reach got e=%b db=%h rs=%b expected 1/5/1", lcd_e, lcd_db, lcd_rs);
      end
      sys0_rstn = 1'b0;
      #1;
      checks++;
      if ({lcd_e, lcd_db, lcd_rs, cmd_ready, init_done} !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_immediate got e=%b db=%h rs=%b rdy=%b done=%b expected all 0",
                  lcd_e, lcd_db, lcd_rs, cmd_ready, init_done);
      end
      repeat (3) @(negedge sys0_clk);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_pulses got %0d expected 0", obs_q.size());
      end
      test_init("reinit", 1'b1);
   endtask

   initial begin
      test_reset();
      test_init("init", 1'b0);
      test_bytes();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_bytes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Write-only 4-bit-bus controller for the board's HD44780-class character LCD.
- Drives lcd_db[3:0], lcd_e, lcd_rs and lcd_rw, which go directly to the top-level LCD pins.
- After reset it runs the mandatory power-up/init sequence on its own. It then accepts command/data bytes over a valid/ready handshake and times each transfer and its execution delay.
- Sits inside the FTop infrastructure, downstream of the control-plane register that supplies LCD bytes.

Parameters:
- T_PWRUP, 3000000: cycles of power-up wait before the first init nibble (15 ms at 200 MHz).
- T_INIT1, 820000: wait after the first init nibble 0x3 (4.1 ms).
- T_SETUP, 8: cycles from rs/db valid to E rise.
- T_EPW, 50: cycles E is held high.
- T_HOLD, 4: cycles rs/db are held after E falls.
- T_EXEC, 8000: post-transfer wait for normal commands and data (40 us).
- T_EXEC_LONG, 328000: post-transfer wait for clear/home (1.64 ms).
- CW, 22: width of the down-counter. Every T_* must satisfy 1 <= T_* < 2^CW.

Ports:
- sys0_clk, in, 1: the block's single clock.
- sys0_rstn, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: byte request is present.
- cmd_ready, out, 1: controller can accept a byte.
- cmd_rs, in, 1: 0 = instruction, 1 = data.
- cmd_data, in, 8: byte to send.
- init_done, out, 1: init sequence is complete; sticky until reset.
- lcd_db, out, 4: LCD data nibble.
- lcd_e, out, 1: LCD enable strobe.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read-not-write; held constant 0.

Behaviour:
- Reset:
  - While sys0_rstn = 0: all outputs = 0 and state = PWRUP.
  - Assertion takes effect immediately, including mid-transfer: lcd_e drops at once and any captured byte is discarded.
  - On release the full init sequence reruns.
- Outputs: lcd_* are registered. cmd_ready = (state == IDLE) && init_done, decoded from registers.
- Counter and timing:
  - Each timed state loads the counter with T_x−1 on entry and leaves on the edge where the counter = 0.
  - A timed state therefore lasts exactly T_x cycles.
- States:
  - PWRUP: T_PWRUP cycles, then INIT_NIB.
  - INIT_NIB: four nibble-only writes, 0x3, 0x3, 0x3, 0x2, with rs = 0.
    - Each write is N_SETUP → N_PULSE → N_HOLD (T_SETUP, T_EPW, T_HOLD).
    - Each write is followed by WAIT: T_INIT1 after the first nibble, T_EXEC after the others.
  - INIT_BYTE: four instruction bytes, 0x28, 0x0C, 0x01, 0x06, sent through the byte path below. After the last WAIT, set init_done and go to IDLE.
  - IDLE: on cmd_valid && cmd_ready, capture cmd_rs/cmd_data and go to SETUP_H. Input changes while cmd_ready = 0 are ignored.
  - Byte path: SETUP_H → PULSE_H → HOLD_H → SETUP_L → PULSE_L → HOLD_L → WAIT.
    - *_H phases drive lcd_db = data[7:4]; *_L phases drive data[3:0].
    - lcd_rs = captured rs throughout.
    - lcd_e = 1 only in PULSE_*.
    - After the transfer: back to the calling sequence, or to IDLE.
  - WAIT length after a byte:
    - T_EXEC_LONG if rs = 0 and data ∈ {0x01, 0x02, 0x03}.
    - T_EXEC otherwise, including 0x00 and 0x04.
- Throughput: each accepted byte keeps cmd_ready low for 2·(T_SETUP+T_EPW+T_HOLD)+WAIT cycles. With cmd_valid held high, cmd_ready is high for exactly one cycle between back-to-back bytes.
- Output hold: lcd_db and lcd_rs keep their last values in IDLE and WAIT; lcd_e = 0.
- Hazards: no read/busy-flag polling, since lcd_rw is permanently 0.

Test Plan:
(Bench overrides: T_PWRUP=20, T_INIT1=10, T_SETUP=2, T_EPW=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=12.)
1. Release reset, cmd_valid = 0 →
   - lcd_e pulses 12 times; sampled lcd_db per pulse = 3,3,3,2,2,8,0,C,0,1,0,6.
   - Each pulse is 3 cycles wide; lcd_rs = 0; lcd_rw = 0.
   - init_done and cmd_ready rise 144 cycles after release (20 + 49 + 75).
2. After init, send rs=1, data=0x41 →
   - lcd_db = 4 then 1 on the two E pulses; lcd_rs = 1.
   - cmd_ready low for 17 cycles, then high.
3. Send rs=0, 0x01 → cmd_ready low 24 cycles. Send rs=0, 0x04 → low 17 cycles. Send rs=1, 0x01 → low 17 cycles.
4. Hold cmd_valid high with 0x48 then 0x49 (rs=1) →
   - Both accepted, 17 cycles apart; cmd_ready high exactly one cycle between.
   - Second byte's nibbles = 4, 9.
5. Assert sys0_rstn = 0 during PULSE_H of a data byte →
   - lcd_e, lcd_db, lcd_rs, cmd_ready and init_done go to 0 immediately.
   - After release, scenario 1 sequence repeats with init_done at 144 cycles.
6. Toggle cmd_valid/cmd_data before init_done and during WAIT → no extra E pulses; bytes are not captured.
